// File: rtl/window_coeff_loader.sv
// Settings-bus fed coefficient FIFO that replays coefficients as an AXI-stream
// load with tlast on the programmed window boundary, plus load status flags.
module window_coeff_loader #(
    parameter logic [7:0]  SR_COEFF_LEN            = 8'd0,
    parameter logic [7:0]  SR_COEFF_DATA           = 8'd1,
    parameter int unsigned MAX_LOG2_OF_WINDOW_SIZE = 10,
    parameter int unsigned COEFF_WIDTH             = 16,
    parameter int unsigned FIFO_LOG2               = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   set_stb,
    input  logic [7:0]             set_addr,
    input  logic [31:0]            set_data,
    output logic [COEFF_WIDTH-1:0] o_coeff_tdata,
    output logic                   o_coeff_tlast,
    output logic                   o_coeff_tvalid,
    input  logic                   o_coeff_tready,
    output logic                   busy,
    output logic                   loaded,
    output logic                   overrun,
    output logic                   len_err
);

    localparam int unsigned DEPTH = 2 ** FIFO_LOG2;
    localparam int unsigned CW    = FIFO_LOG2 + 1;
    localparam int unsigned IW    = MAX_LOG2_OF_WINDOW_SIZE;

    localparam logic [FIFO_LOG2-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0]        CNT_ONE = 1;
    localparam logic [CW-1:0]        CNT_MAX = DEPTH[CW-1:0];
    localparam logic [IW-1:0]        IDX_ONE = 1;

    logic [COEFF_WIDTH-1:0] r_mem [DEPTH];
    logic [FIFO_LOG2-1:0]   r_wr_ptr;
    logic [FIFO_LOG2-1:0]   r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [IW-1:0]          r_index;
    logic [IW-1:0]          r_last_index;
    logic                   r_loaded;
    logic                   r_overrun;
    logic                   r_len_err;

    logic w_full;
    logic w_empty;
    logic w_push_req;
    logic w_push;
    logic w_pop;
    logic w_len_req;
    logic w_last;
    logic w_busy;

    assign w_full     = (r_count == CNT_MAX);
    assign w_empty    = (r_count == '0);
    assign w_push_req = set_stb && (set_addr == SR_COEFF_DATA);
    // Fullness is judged before any same-cycle pop, so a full FIFO drops the push.
    assign w_push     = w_push_req && !w_full;
    assign w_pop      = !w_empty && o_coeff_tready;
    assign w_len_req  = set_stb && (set_addr == SR_COEFF_LEN);
    assign w_last     = (r_index == r_last_index);
    assign w_busy     = !w_empty || (r_index != '0);

    assign o_coeff_tvalid = !w_empty;
    assign o_coeff_tdata  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_coeff_tlast  = w_last && !w_empty;
    assign busy           = w_busy;
    assign loaded         = r_loaded;
    assign overrun        = r_overrun;
    assign len_err        = r_len_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= set_data[COEFF_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_index      <= '0;
            r_last_index <= '1;
            r_loaded     <= 1'b0;
            r_overrun    <= 1'b0;
            r_len_err    <= 1'b0;
        end else if (clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_index      <= '0;
            r_loaded     <= 1'b0;
            r_overrun    <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                if (w_last) begin
                    r_index  <= '0;
                    r_loaded <= 1'b1;
                end else begin
                    r_index <= r_index + IDX_ONE;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full) begin
                r_overrun <= 1'b1;
            end
            if (w_len_req) begin
                if (w_busy) begin
                    r_len_err <= 1'b1;
                end else begin
                    r_last_index <= set_data[IW-1:0];
                    r_loaded     <= 1'b0;
                end
            end
            // A new coefficient invalidates completion, even against a same-cycle tlast.
            if (w_push) begin
                r_loaded <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_coeff_loader.sv
// Directed bench for window_coeff_loader: ordering, tlast placement, overrun,
// length-write rejection, stall stability, clear, async reset and full wrap.
module tb_window_coeff_loader;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [15:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    logic        busy;
    logic        loaded;
    logic        overrun;
    logic        len_err;

    int total;
    int bad;

    window_coeff_loader #(
        .SR_COEFF_LEN            (8'd0),
        .SR_COEFF_DATA           (8'd1),
        .MAX_LOG2_OF_WINDOW_SIZE (10),
        .COEFF_WIDTH             (16),
        .FIFO_LOG2               (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (clear),
        .set_stb        (set_stb),
        .set_addr       (set_addr),
        .set_data       (set_data),
        .o_coeff_tdata  (tdata),
        .o_coeff_tlast  (tlast),
        .o_coeff_tvalid (tvalid),
        .o_coeff_tready (tready),
        .busy           (busy),
        .loaded         (loaded),
        .overrun        (overrun),
        .len_err        (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = data;
        tick();
        set_stb  = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset_n  = 1'b0;
        clear    = 1'b0;
        set_stb  = 1'b0;
        set_addr = 8'd0;
        set_data = 32'd0;
        tready   = 1'b0;
        #12;
        chk("rst_tvalid",  32'(tvalid),  32'd0);
        chk("rst_tlast",   32'(tlast),   32'd0);
        chk("rst_tdata",   32'(tdata),   32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_loaded",  32'(loaded),  32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        reset_n = 1'b1;
        tick();

        // Window of 4 streamed straight through.
        wr(8'd0, 32'd3);
        tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_stb  = 1'b1;
            set_addr = 8'd1;
            set_data = 32'(i);
            tick();
            chk("t1_tvalid", 32'(tvalid), 32'd1);
            chk("t1_tdata",  32'(tdata),  32'(i));
            chk("t1_tlast",  32'(tlast),  32'(i == 4));
        end
        set_stb = 1'b0;
        tick();
        chk("t1_loaded", 32'(loaded), 32'd1);
        chk("t1_busy",   32'(busy),   32'd0);
        chk("t1_tvalid_end", 32'(tvalid), 32'd0);

        // Fill while stalled: fifth push dropped.
        wr(8'd0, 32'd1);
        chk("t2_loaded_lenwr", 32'(loaded), 32'd0);
        tready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wr(8'd1, 32'h10 + 32'(i));
        end
        chk("t2_overrun", 32'(overrun), 32'd1);
        chk("t2_head",    32'(tdata),   32'h11);
        tready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t2_tdata", 32'(tdata), 32'h10 + 32'(k));
            chk("t2_tlast", 32'(tlast), 32'((k % 2) == 0));
            tick();
        end
        chk("t2_tvalid_end", 32'(tvalid), 32'd0);
        chk("t2_loaded",     32'(loaded), 32'd1);
        chk("t2_busy",       32'(busy),   32'd0);

        // Length write while busy is rejected.
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        tready = 1'b0;
        wr(8'd1, 32'h55);
        chk("t3_tvalid", 32'(tvalid), 32'd1);
        wr(8'd0, 32'd7);
        chk("t3_len_err", 32'(len_err), 32'd1);
        chk("t3_tlast",   32'(tlast),   32'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t3_hold_tdata", 32'(tdata), 32'h55);
            chk("t3_hold_tlast", 32'(tlast), 32'd0);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_tvalid",  32'(tvalid),  32'd0);
        chk("clr_tdata",   32'(tdata),   32'd0);
        chk("clr_busy",    32'(busy),    32'd0);
        chk("clr_len_err", 32'(len_err), 32'd0);
        chk("clr_overrun", 32'(overrun), 32'd0);
        chk("clr_loaded",  32'(loaded),  32'd0);

        // last_index survives clear.
        wr(8'd0, 32'd2);
        chk("t3_len_ok", 32'(len_err), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_stb  = 1'b1;
            set_addr = 8'd1;
            set_data = 32'h60 + 32'(i);
            tick();
            chk("ret_tdata", 32'(tdata), 32'h60 + 32'(i));
            chk("ret_tlast", 32'(tlast), 32'(i == 3));
        end
        set_stb = 1'b0;
        tick();
        chk("ret_loaded", 32'(loaded), 32'd1);

        // Window of one: every beat carries tlast; push beats same-cycle tlast.
        wr(8'd0, 32'd0);
        set_stb  = 1'b1;
        set_addr = 8'd1;
        set_data = 32'hABCD;
        tick();
        chk("t4_tdata0", 32'(tdata), 32'hABCD);
        chk("t4_tlast0", 32'(tlast), 32'd1);
        set_data = 32'h1234;
        tick();
        set_stb = 1'b0;
        chk("t4_tdata1",  32'(tdata),  32'h1234);
        chk("t4_tlast1",  32'(tlast),  32'd1);
        chk("t4_loaded0", 32'(loaded), 32'd0);
        tick();
        chk("t4_loaded1", 32'(loaded), 32'd1);
        wr(8'd2, 32'h99);
        chk("t4_a2_tvalid", 32'(tvalid), 32'd0);
        chk("t4_a2_loaded", 32'(loaded), 32'd1);
        chk("t4_a2_busy",   32'(busy),   32'd0);
        tready = 1'b0;
        wr(8'd1, 32'h77);
        chk("t4_a2_tlast", 32'(tlast), 32'd1);
        tready = 1'b1;
        tick();
        chk("t4_a2_loaded2", 32'(loaded), 32'd1);

        // Async reset mid-load at index 2.
        wr(8'd0, 32'd3);
        tready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wr(8'd1, 32'h20 + 32'(i));
        end
        tready = 1'b1;
        tick();
        tick();
        chk("t5_tdata_mid", 32'(tdata), 32'h23);
        chk("t5_tlast_mid", 32'(tlast), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", 32'(tvalid), 32'd0);
        chk("t5_rst_tdata",  32'(tdata),  32'd0);
        chk("t5_rst_busy",   32'(busy),   32'd0);
        chk("t5_rst_tlast",  32'(tlast),  32'd0);
        #2 reset_n = 1'b1;
        tick();

        // Default length is the full 1024-entry window.
        for (int i = 1; i <= 1024; i++) begin
            set_stb  = 1'b1;
            set_addr = 8'd1;
            set_data = 32'(i);
            tick();
            chk("wrap_tdata", 32'(tdata), 32'(i & 16'hFFFF));
            chk("wrap_tlast", 32'(tlast), 32'(i == 1024));
        end
        set_stb = 1'b0;
        tick();
        chk("wrap_loaded", 32'(loaded), 32'd1);
        chk("wrap_busy",   32'(busy),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
